// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: request encodings, state codes and helpers shared by the MEM stage and mem_ctrl
package mem_ctrl_pkg;
  localparam logic [1:0] MEM_NOP  = 2'b00;
  localparam logic [1:0] MEM_LOAD = 2'b01;
  localparam logic [1:0] MEM_SAVE = 2'b10;
  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;
  localparam logic [31:0] ZERO_WORD = 32'd0;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STORE, S_FETCH, S_DONE} state_t;
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    return len == MEM_BYTE ? 3'd1 : len == MEM_HALF ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises MEM loads/stores and IF word fetches onto a byte-wide RAM port
// MEM requests win arbitration; fin pulses go to the owner of the finished transfer.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic [1:0]        memctl_op,
  input  logic [1:0]        memctl_len,
  input  logic [31:0]       memctl_addr,
  input  logic [31:0]       memctl_data,
  output logic              memctl_fin,
  output logic [31:0]       memctl_out,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  input  logic              if_clr,
  output logic              if_fin,
  output logic [31:0]       if_data,
  output logic [ADDR_W-1:0] ram_a,
  output logic [7:0]        ram_dout,
  output logic              ram_wr,
  input  logic [7:0]        ram_din
);
  state_t            r_state;
  logic [31:0]       r_addr, r_data, r_buf, r_mout, r_ifout;
  logic [2:0]        r_n, r_rx;
  logic              r_v, r_src, r_wr;
  logic [ADDR_W-1:0] r_ram_a;
  logic [7:0]        r_dout;
  logic              w_mem, w_save, w_if, w_last;
  logic [2:0]        w_rx_nx;
  logic [1:0]        w_st_nx;
  logic [31:0]       w_req_a, w_a_iss, w_a_rx, w_a_st, w_buf;
  // r_v: the address on ram_a last cycle was a live read of byte r_rx
  always_comb begin
    w_mem   = memctl_op == MEM_LOAD || memctl_op == MEM_SAVE;
    w_save  = memctl_op == MEM_SAVE;
    w_if    = !w_mem && if_req && !if_clr;
    w_req_a = w_mem ? memctl_addr : if_addr;
    w_rx_nx = r_rx + {2'b0, r_v};
    w_last  = r_v && r_rx == r_n - 3'd1;
    w_st_nx = r_rx[1:0] + 2'd1;
    w_a_iss = r_addr + {29'd0, w_rx_nx + 3'd1};
    w_a_rx  = r_addr + {29'd0, r_rx};
    w_a_st  = r_addr + {29'd0, r_rx + 3'd1};
    w_buf   = r_buf;
    w_buf[8*r_rx[1:0] +: 8] = ram_din;
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
      r_addr  <= ZERO_WORD;
      r_data  <= ZERO_WORD;
      r_buf   <= ZERO_WORD;
      r_mout  <= ZERO_WORD;
      r_ifout <= ZERO_WORD;
      r_n     <= 3'd0;
      r_rx    <= 3'd0;
      r_v     <= 1'b0;
      r_src   <= 1'b0;
      r_wr    <= 1'b0;
      r_ram_a <= '0;
      r_dout  <= 8'd0;
    end else if (rdy_in) begin
      case (r_state)
        S_IDLE: if (w_mem || w_if) begin
          r_addr  <= w_req_a;
          r_n     <= w_mem ? len_bytes(memctl_len) : 3'd4;
          r_data  <= memctl_data;
          r_src   <= w_if;
          r_rx    <= 3'd0;
          r_v     <= 1'b0;
          r_buf   <= ZERO_WORD;
          r_ram_a <= w_req_a[ADDR_W-1:0];
          r_dout  <= memctl_data[7:0];
          r_wr    <= w_mem && w_save;
          r_state <= w_if ? S_FETCH : w_save ? S_STORE : S_LOAD;
        end
        S_LOAD, S_FETCH: if (r_state == S_FETCH && if_clr) begin
          r_v     <= 1'b0;
          r_state <= S_IDLE;
        end else begin
          if (r_v) begin
            r_buf <= w_buf;
            r_rx  <= r_rx + 3'd1;
          end
          if (w_last) begin
            r_v     <= 1'b0;
            r_state <= S_DONE;
            if (r_src) r_ifout <= w_buf;
            else r_mout <= w_buf;
          end else begin
            r_v <= 1'b1;
            if (w_rx_nx + 3'd1 < r_n) r_ram_a <= w_a_iss[ADDR_W-1:0];
          end
        end
        S_STORE: if (r_rx == r_n - 3'd1) begin
          r_wr    <= 1'b0;
          r_state <= S_DONE;
        end else begin
          r_rx    <= r_rx + 3'd1;
          r_ram_a <= w_a_st[ADDR_W-1:0];
          r_dout  <= r_data[8*w_st_nx +: 8];
        end
        default: r_state <= S_IDLE;
      endcase
    end else if (r_state == S_LOAD || r_state == S_FETCH) begin
      // a paused cycle loses the in-flight response, so rewind to re-issue it
      r_v     <= 1'b0;
      r_ram_a <= w_a_rx[ADDR_W-1:0];
    end
  end
  assign ram_a      = r_ram_a;
  assign ram_dout   = r_dout;
  assign ram_wr     = r_wr && rdy_in;
  assign memctl_fin = r_state == S_DONE && !r_src && rdy_in;
  assign if_fin     = r_state == S_DONE && r_src && rdy_in;
  assign memctl_out = r_mout;
  assign if_data    = r_ifout;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed checks of mem_ctrl timing, arbitration, pause, flush and reset
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;
  logic        clk_in, rst_in, rdy_in;
  logic [1:0]  memctl_op, memctl_len;
  logic [31:0] memctl_addr, memctl_data, memctl_out;
  logic        memctl_fin;
  logic        if_req, if_clr, if_fin;
  logic [31:0] if_addr, if_data;
  logic [31:0] ram_a;
  logic [7:0]  ram_dout, ram_din;
  logic        ram_wr;
  bit [7:0]    wmem [256];
  bit [255:0]  wv;
  int          n_wr, n_mf, n_if;
  bit          overlap;
  int          n_cmp, n_err;
  int          n, mf, ff, wc, fc, ic;
  logic [31:0] mo, fd;

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .memctl_op(memctl_op), .memctl_len(memctl_len), .memctl_addr(memctl_addr),
    .memctl_data(memctl_data), .memctl_fin(memctl_fin), .memctl_out(memctl_out),
    .if_req(if_req), .if_addr(if_addr), .if_clr(if_clr), .if_fin(if_fin), .if_data(if_data),
    .ram_a(ram_a), .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_din(ram_din)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  function automatic logic [7:0] init_val(input logic [7:0] a);
    case (a)
      8'h10: return 8'hA5;
      8'h20: return 8'h11;
      8'h21: return 8'h22;
      8'h22: return 8'h33;
      8'h23: return 8'h44;
      8'h42: return 8'h77;
      8'h50: return 8'h5A;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] rd(input logic [7:0] a);
    return wv[a] ? wmem[a] : init_val(a);
  endfunction

  always @(posedge clk_in) begin
    ram_din <= rd(ram_a[7:0]);
    if (ram_wr) begin
      wmem[ram_a[7:0]] <= ram_dout;
      wv[ram_a[7:0]]   <= 1'b1;
      n_wr             <= n_wr + 1;
    end
  end

  always @(negedge clk_in) begin
    #1;
    if (memctl_fin && if_fin) overlap = 1'b1;
    if (memctl_fin) n_mf = n_mf + 1;
    if (if_fin) n_if = n_if + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] len, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk_in);
    memctl_op = op; memctl_len = len; memctl_addr = a; memctl_data = d;
    #1;
  endtask

  task automatic wait_mfin(input int base, output int cyc);
    cyc = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk_in);
      memctl_op = MEM_NOP;
      #1;
      if (memctl_fin) begin
        cyc = base + i;
        break;
      end
    end
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1;
    memctl_op = MEM_NOP; memctl_len = MEM_BYTE; memctl_addr = 0; memctl_data = 0;
    if_req = 1'b0; if_addr = 0; if_clr = 1'b0;
    repeat (2) @(negedge clk_in);
    #1;
    chk("rst_ram_a", ram_a, 32'h0);
    chk("rst_ram_wr", 32'(ram_wr), 32'h0);
    chk("rst_memctl_fin", 32'(memctl_fin), 32'h0);
    chk("rst_if_fin", 32'(if_fin), 32'h0);
    chk("rst_memctl_out", memctl_out, 32'h0);
    chk("rst_if_data", if_data, 32'h0);
    @(negedge clk_in);
    rst_in = 1'b0;
    // byte load
    issue(MEM_LOAD, MEM_BYTE, 32'h10, 32'h0);
    @(negedge clk_in);
    memctl_op = MEM_NOP;
    #1;
    chk("lb_ram_a_t1", ram_a, 32'h10);
    chk("lb_ram_wr_t1", 32'(ram_wr), 32'h0);
    wait_mfin(1, n);
    chk("lb_fin_cycle", n, 32'd3);
    chk("lb_out", memctl_out, 32'h000000A5);
    // word load
    issue(MEM_LOAD, MEM_WORD, 32'h20, 32'h0);
    wait_mfin(0, n);
    chk("lw_fin_cycle", n, 32'd6);
    chk("lw_out", memctl_out, 32'h44332211);
    // half store
    issue(MEM_SAVE, MEM_HALF, 32'h40, 32'hDEADBEEF);
    @(negedge clk_in);
    memctl_op = MEM_NOP;
    #1;
    chk("sh_wr_t1", 32'(ram_wr), 32'h1);
    chk("sh_a_t1", ram_a, 32'h40);
    chk("sh_dout_t1", 32'(ram_dout), 32'hEF);
    @(negedge clk_in);
    #1;
    chk("sh_wr_t2", 32'(ram_wr), 32'h1);
    chk("sh_a_t2", ram_a, 32'h41);
    chk("sh_dout_t2", 32'(ram_dout), 32'hBE);
    chk("sh_fin_t2", 32'(memctl_fin), 32'h0);
    @(negedge clk_in);
    #1;
    chk("sh_fin_t3", 32'(memctl_fin), 32'h1);
    chk("sh_wr_t3", 32'(ram_wr), 32'h0);
    chk("sh_ram40", 32'(rd(8'h40)), 32'hEF);
    chk("sh_ram41", 32'(rd(8'h41)), 32'hBE);
    chk("sh_ram42", 32'(rd(8'h42)), 32'h77);
    // MEM and IF collide in one IDLE cycle
    @(negedge clk_in);
    memctl_op = MEM_LOAD; memctl_len = MEM_BYTE; memctl_addr = 32'h50;
    if_req = 1'b1; if_addr = 32'h20;
    #1;
    mf = -1; ff = -1; mo = 0; fd = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk_in);
      memctl_op = MEM_NOP;
      #1;
      if (memctl_fin && mf < 0) begin
        mf = i;
        mo = memctl_out;
      end
      if (if_fin) begin
        ff = i;
        fd = if_data;
        if_req = 1'b0;
        break;
      end
    end
    chk("arb_mem_fin_cycle", mf, 32'd3);
    chk("arb_mem_out", mo, 32'h5A);
    chk("arb_if_fin_cycle", ff, 32'd10);
    chk("arb_if_data", fd, 32'h44332211);
    // word load with two paused cycles
    wc = n_wr;
    issue(MEM_LOAD, MEM_WORD, 32'h20, 32'h0);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk_in);
      memctl_op = MEM_NOP;
      rdy_in = !(i == 3 || i == 4);
      #1;
      if (!rdy_in) chk("pause_fin", 32'(memctl_fin), 32'h0);
      if (memctl_fin) begin
        n = i;
        break;
      end
    end
    rdy_in = 1'b1;
    chk("pause_fin_cycle", n, 32'd9);
    chk("pause_out", memctl_out, 32'h44332211);
    chk("pause_no_writes", n_wr, wc);
    // IF flush while byte 2 is on the bus, then a MEM byte store
    ic = n_if;
    @(negedge clk_in);
    if_req = 1'b1; if_addr = 32'h20;
    #1;
    @(negedge clk_in);
    #1;
    @(negedge clk_in);
    #1;
    chk("clr_a_t2", ram_a, 32'h21);
    @(negedge clk_in);
    if_clr = 1'b1; if_req = 1'b0;
    #1;
    chk("clr_a_t3", ram_a, 32'h22);
    @(negedge clk_in);
    if_clr = 1'b0;
    memctl_op = MEM_SAVE; memctl_len = MEM_BYTE; memctl_addr = 32'h60; memctl_data = 32'h123456C3;
    #1;
    wait_mfin(0, n);
    chk("clr_sb_fin_cycle", n, 32'd2);
    chk("clr_sb_ram60", 32'(rd(8'h60)), 32'hC3);
    chk("clr_no_if_fin", n_if, ic);
    // reset in the middle of a word store
    issue(MEM_SAVE, MEM_WORD, 32'h70, 32'h01020304);
    @(negedge clk_in);
    memctl_op = MEM_NOP;
    #1;
    chk("rst_st_wr_t1", 32'(ram_wr), 32'h1);
    chk("rst_st_a_t1", ram_a, 32'h70);
    @(negedge clk_in);
    rst_in = 1'b1;
    #1;
    @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    chk("rst_st_wr_after", 32'(ram_wr), 32'h0);
    chk("rst_st_a_after", ram_a, 32'h0);
    wc = n_wr; fc = n_mf;
    repeat (6) @(negedge clk_in);
    #1;
    chk("rst_st_no_more_writes", n_wr, wc);
    chk("rst_st_no_fin", n_mf, fc);
    chk("rst_st_ram70", 32'(rd(8'h70)), 32'h04);
    chk("rst_st_ram71", 32'(rd(8'h71)), 32'h03);
    chk("rst_st_ram72", 32'(rd(8'h72)), 32'h00);
    chk("rst_st_ram73", 32'(rd(8'h73)), 32'h00);
    chk("fin_overlap", 32'(overlap), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
